gpio_decimal_entry: RTL and testbench
=====================================

# gpio_decimal_entry

Keypad-style decimal input peripheral: the input-side counterpart of the binary-to-7-segment output path. The user selects a digit on four slide switches and presses push-buttons to append, clear, or commit. The block accumulates a binary value, up to MAX_DIGITS decimal digits, and presents the committed 32-bit value to the CPU as a read-once word with a valid flag. The live accumulator is also exported so the existing display path can echo the entry as it is typed.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key's debounced level changes (10 ms at 50 MHz).
- MAX_DIGITS, 5: maximum digits per entry; matches the 5-digit display.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw  in  4  digit select; values 0-9 are legal, 10-15 are illegal
- key_n  in  3  asynchronous push-buttons, active-low; [0] append, [1] clear, [2] commit
- rd_en  in  1  CPU read strobe for data_out
- data_out  out  32  last committed value
- valid  out  1  committed value not yet read
- entry_value  out  32  live accumulator, for the display
- digit_count  out  3  digits entered so far in the current entry
- err  out  1  sticky error: illegal digit or append when full

## Operation
- Each key_n bit passes through a 2-FF synchronizer and then a debouncer.
  - The debounced level changes only after the synchronized raw level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- A press event is a 1-cycle pulse on the debounced 1->0 transition. Release produces no event.
- Entry FSM (gpio_pkg::entry_state_t):
  - EMPTY: digit_count=0.
  - ENTRY: 0 < digit_count < MAX_DIGITS.
  - FULL: digit_count = MAX_DIGITS.
- Append event:
  - sw <= 9 and state != FULL: acc <= acc*10 + sw, digit_count += 1. EMPTY->ENTRY, or ENTRY->FULL on reaching MAX_DIGITS.
  - Leading zeros count as digits.
  - sw > 9 or state == FULL: acc is unchanged and err <= 1.
- Clear event: acc <= 0, digit_count <= 0, err <= 0, go to EMPTY. data_out and valid are untouched.
- Commit event (any state, including EMPTY, which commits 0):
  - data_out <= acc, valid <= 1.
  - acc and digit_count are zeroed, go to EMPTY.
  - err is kept.
- Simultaneous events in one cycle: clear > commit > append. Only the highest-priority event acts; the others are dropped.
- Commit while valid=1 overwrites data_out and leaves valid=1. The older value is lost, by design.
- rd_en while valid=1: valid <= 0. data_out holds.
- rd_en while valid=0: no effect.
- Commit and rd_en in the same cycle: commit wins, valid stays 1, data_out takes the new value.
- Arithmetic: acc is 32 bits; acc*10 + sw is computed at 32 bits. With MAX_DIGITS <= 9 it never overflows. Max at default is 99999.
- entry_value = acc; digit_count mirrors the counter.

## Timing
- Reset: all synchronizer and debouncer state goes to the released level (1).
  - Debounce counters, acc, digit_count, data_out = 0.
  - valid = 0, err = 0, state = EMPTY.
  - No press event may fire on the first cycles after reset.
- Key latency: a clean press seen on key_n at cycle t gives an event pulse at t + 2 + DEBOUNCE_CYCLES, ±1 for the sample edge. Register outputs update one cycle after the pulse.
- rd_en at cycle t -> valid low at t+1.
- All outputs are registered; no combinational path from inputs to outputs.
- rst mid-debounce or mid-entry: everything returns to reset values on the next edge. A key held through reset must be released and re-pressed to generate an event.

## Structure
- gpio_pkg holds:
  - entry_state_t enum {EMPTY, ENTRY, FULL}
  - key index constants KEY_APPEND=0, KEY_CLEAR=1, KEY_COMMIT=2
  - the digit width constant (4)
- Sub-module key_debounce: synchronizer, debounce counter and falling-edge pulse for one key, parameterized by DEBOUNCE_CYCLES. Instantiated three times.
- The top level holds the entry FSM, accumulator and CPU handshake.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Clean entry: press append with sw=1,2,3,4,5, then commit -> data_out=12345, valid=1, digit_count=0, entry_value=0. rd_en -> valid=0 next cycle, data_out still 12345.
- Bounce: key_n toggles 3 cycles low, 1 high, 3 low, then stays low -> exactly one append event, 2+4 cycles after the final stable low.
- Limits: 5 appends of sw=9, then one more -> entry_value=99999, state FULL, err=1. Append with sw=12 also sets err. Clear -> err=0, entry_value=0.
- Priority: debounced clear and commit events in the same cycle -> acc=0, valid unchanged. Commit and rd_en in the same cycle with valid=1 -> valid stays 1 with the new value.
- Empty commit and overwrite: commit with no digits -> data_out=0, valid=1. Enter 7, commit without reading -> data_out=7, valid=1.
- Reset mid-entry: after 3 digits (entry_value=123), assert rst for 1 cycle with key 0 held low -> all outputs 0, no append event until the key is released and re-pressed.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and constants for the decimal-entry GPIO peripheral.
package gpio_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } entry_state_t;

  localparam int KEY_APPEND = 0;
  localparam int KEY_CLEAR  = 1;
  localparam int KEY_COMMIT = 2;
  localparam int NUM_KEYS   = 3;

  localparam int DIGIT_W = 4;

  // True when the switch setting is a legal decimal digit (0-9).
  function automatic logic is_digit(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/gpio_decimal_entry_if.sv
// CPU-side read handshake of the decimal-entry peripheral.
interface gpio_decimal_entry_if;
  logic        rd_en;
  logic [31:0] data_out;
  logic        valid;

  // CPU side: issues reads, observes the committed word.
  modport master (output rd_en, input data_out, input valid);
  // Peripheral side: presents the committed word, consumes reads.
  modport slave  (input rd_en, output data_out, output valid);
endinterface

// File: rtl/gpio_decimal_entry_key_debounce.sv
// One push-button: 2-FF synchronizer, stability counter, press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  // fill marks when sync2 carries a sample taken after reset; armed is set
  // once such a sample shows the key released, so a key held through reset
  // never produces a press until it is released and pressed again.
  logic [1:0]       fill;
  logic             armed;

  // Synchronize, count consecutive disagreeing cycles, flip level and pulse.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fill  <= '0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      press <= 1'b0;
      if (fill[1] && sync2) begin
        armed <= 1'b1;
      end
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          // level is still 1 here only for a release-to-press transition
          press <= armed && level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_decimal_entry.sv
// Decimal keypad entry: debounced keys drive an accumulator FSM whose
// committed value is offered to the CPU as a read-once word.
module gpio_decimal_entry
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGIT_W-1:0]    sw,
  input  logic [NUM_KEYS-1:0]   key_n,
  gpio_decimal_entry_if.slave   cpu,
  output logic [31:0]           entry_value,
  output logic [2:0]            digit_count,
  output logic                  err
);

  logic [NUM_KEYS-1:0] press;

  entry_state_t state_q, state_d;
  logic [31:0]  acc_q,   acc_d;
  logic [2:0]   cnt_q,   cnt_d;
  logic [31:0]  data_q,  data_d;
  logic         valid_q, valid_d;
  logic         err_q,   err_d;

  logic ev_clear;
  logic ev_commit;
  logic ev_append;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[k]),
      .press (press[k])
    );
  end

  // Only the highest-priority event in a cycle acts.
  assign ev_clear  = press[KEY_CLEAR];
  assign ev_commit = press[KEY_COMMIT] && !ev_clear;
  assign ev_append = press[KEY_APPEND] && !ev_clear && !press[KEY_COMMIT];

  // Next-state logic for the entry FSM, accumulator and CPU handshake.
  // NOTE: every variable gets its hold value first, so no path through the
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;

    if (cpu.rd_en) begin
      valid_d = 1'b0;
    end

    if (ev_clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      state_d = EMPTY;
    end else if (ev_commit) begin
      // a commit in the same cycle as a read wins: the new word stays valid
      data_d  = acc_q;
      valid_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = EMPTY;
    end else if (ev_append) begin
      if (is_digit(sw) && state_q != FULL) begin
        acc_d   = acc_q * 32'd10 + 32'(sw);
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_d == 3'(MAX_DIGITS)) ? FULL : ENTRY;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign entry_value  = acc_q;
  assign digit_count  = cnt_q;
  assign err          = err_q;
  assign cpu.data_out = data_q;
  assign cpu.valid    = valid_q;

endmodule

// File: tb/tb_gpio_decimal_entry.sv
// Directed bench for gpio_decimal_entry with a short debounce window.
module tb_gpio_decimal_entry;
  import gpio_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'd0;
  logic [2:0] key_n = 3'b111;
  logic [31:0] entry_value;
  logic [2:0]  digit_count;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  gpio_decimal_entry_if cpu();

  gpio_decimal_entry #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .key_n       (key_n),
    .cpu         (cpu),
    .entry_value (entry_value),
    .digit_count (digit_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Press the keys in mask cleanly, hold, then release; ends on a negedge.
  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    key_n = key_n & ~mask;
    repeat (10) @(negedge clk);
    key_n = key_n | mask;
    repeat (10) @(negedge clk);
  endtask

  task automatic append(input logic [3:0] d);
    sw = d;
    press(3'b001);
  endtask

  initial begin
    int first;
    int changes;
    logic [2:0] prev;
    logic [3:0] pat;

    cpu.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_entry", entry_value, 0);
    check("rst_count", 32'(digit_count), 0);
    check("rst_err", 32'(err), 0);
    check("rst_valid", 32'(cpu.valid), 0);
    check("rst_data", cpu.data_out, 0);
    repeat (20) @(negedge clk);
    check("rst_no_event", 32'(digit_count), 0);

    // Clean entry 12345 and commit, then read
    for (int d = 1; d <= 5; d++) append(4'(d));
    check("clean_entry", entry_value, 12345);
    check("clean_count", 32'(digit_count), 5);
    press(3'b100);
    check("clean_data", cpu.data_out, 12345);
    check("clean_valid", 32'(cpu.valid), 1);
    check("clean_count0", 32'(digit_count), 0);
    check("clean_entry0", entry_value, 0);
    cpu.rd_en = 1'b1;
    @(negedge clk);
    cpu.rd_en = 1'b0;
    check("read_valid", 32'(cpu.valid), 0);
    check("read_data", cpu.data_out, 12345);

    // Bounce: low 3, high 1, then low for good
    sw = 4'd6;
    pat = 4'b1000;
    first = -1;
    changes = 0;
    prev = digit_count;
    for (int i = 0; i < 20; i++) begin
      key_n[0] = (i < 4) ? pat[i] : 1'b0;
      @(negedge clk);
      if (digit_count != prev) begin
        changes++;
        if (first < 0) first = i;
        prev = digit_count;
      end
    end
    key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_latency", 32'(first), 10);
    check("bounce_once", 32'(changes), 1);
    check("bounce_entry", entry_value, 6);

    // Limits: full entry, overflow append, illegal digit
    press(3'b010);
    for (int d = 0; d < 5; d++) append(4'd9);
    check("full_entry", entry_value, 99999);
    check("full_count", 32'(digit_count), 5);
    check("full_err0", 32'(err), 0);
    append(4'd9);
    check("over_entry", entry_value, 99999);
    check("over_count", 32'(digit_count), 5);
    check("over_err", 32'(err), 1);
    press(3'b010);
    check("clear_err", 32'(err), 0);
    check("clear_entry", entry_value, 0);
    append(4'd12);
    check("illegal_err", 32'(err), 1);
    check("illegal_entry", entry_value, 0);
    check("illegal_count", 32'(digit_count), 0);
    press(3'b010);

    // Leading zeros count as digits
    append(4'd0);
    append(4'd0);
    check("lead0_count", 32'(digit_count), 2);
    check("lead0_entry", entry_value, 0);
    press(3'b010);

    // Empty commit, then overwrite without reading
    press(3'b100);
    check("empty_data", cpu.data_out, 0);
    check("empty_valid", 32'(cpu.valid), 1);
    append(4'd7);
    press(3'b100);
    check("over_data", cpu.data_out, 7);
    check("over_valid", 32'(cpu.valid), 1);

    // Clear beats commit
    append(4'd4);
    press(3'b110);
    check("prio_cc_entry", entry_value, 0);
    check("prio_cc_count", 32'(digit_count), 0);
    check("prio_cc_data", cpu.data_out, 7);
    check("prio_cc_valid", 32'(cpu.valid), 1);

    // Commit beats append
    append(4'd8);
    sw = 4'd3;
    press(3'b101);
    check("prio_ca_data", cpu.data_out, 8);
    check("prio_ca_entry", entry_value, 0);
    check("prio_ca_count", 32'(digit_count), 0);

    // Commit and read in the same cycle (event acts at the 7th edge)
    append(4'd5);
    @(negedge clk);
    key_n[2] = 1'b0;
    repeat (6) @(negedge clk);
    cpu.rd_en = 1'b1;
    @(negedge clk);
    cpu.rd_en = 1'b0;
    check("cr_valid", 32'(cpu.valid), 1);
    check("cr_data", cpu.data_out, 5);
    key_n[2] = 1'b1;
    repeat (10) @(negedge clk);
    cpu.rd_en = 1'b1;
    @(negedge clk);
    cpu.rd_en = 1'b0;
    check("cr_read_valid", 32'(cpu.valid), 0);
    cpu.rd_en = 1'b1;
    @(negedge clk);
    cpu.rd_en = 1'b0;
    check("idle_read_data", cpu.data_out, 5);

    // Reset mid-entry with the append key held
    for (int d = 1; d <= 3; d++) append(4'(d));
    check("pre_rst_entry", entry_value, 123);
    press(3'b100);
    append(4'd12);
    append(4'd1);
    check("pre_rst_err", 32'(err), 1);
    sw = 4'd2;
    key_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_entry", entry_value, 0);
    check("mid_rst_count", 32'(digit_count), 0);
    check("mid_rst_valid", 32'(cpu.valid), 0);
    check("mid_rst_data", cpu.data_out, 0);
    check("mid_rst_err", 32'(err), 0);
    repeat (20) @(negedge clk);
    check("held_no_event", 32'(digit_count), 0);
    key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("release_no_event", 32'(digit_count), 0);
    append(4'd2);
    check("repress_count", 32'(digit_count), 1);
    check("repress_entry", entry_value, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
